// File: rtl/alu_flag_stage_if.sv
// Bus bundle between the execute stage and the ALU flag/branch-resolve stage.
// The master drives the execute-stage fields; the slave returns the registered results.
interface alu_flag_stage_if #(
    parameter int WIDTH = 64
);
    logic [WIDTH-1:0] F;
    logic [3:0]       status;
    logic             valid_in;
    logic             set_flags;
    logic [1:0]       br_type;
    logic [3:0]       cond;
    logic [4:0]       rd;
    logic             reg_write;
    logic             stall;
    logic             flush;

    logic [WIDTH-1:0] result;
    logic [4:0]       rd_out;
    logic             reg_write_out;
    logic             valid_out;
    logic [3:0]       flags;
    logic             branch_taken;

    modport master (
        output F, status, valid_in, set_flags, br_type, cond, rd, reg_write, stall, flush,
        input  result, rd_out, reg_write_out, valid_out, flags, branch_taken
    );

    modport slave (
        input  F, status, valid_in, set_flags, br_type, cond, rd, reg_write, stall, flush,
        output result, rd_out, reg_write_out, valid_out, flags, branch_taken
    );
endinterface

// File: rtl/alu_flag_stage.sv
// One-cycle pipeline stage that registers the ALU result, owns the {V,C,N,Z}
// flag register and resolves B.cond / CBZ / CBNZ branch decisions.
module alu_flag_stage #(
    parameter int WIDTH = 64
) (
    input  logic         clock,
    input  logic         reset,
    alu_flag_stage_if.slave bus
);
    logic [WIDTH-1:0] result_r;
    logic [4:0]       rd_out_r;
    logic             reg_write_out_r;
    logic             valid_out_r;
    logic [3:0]       flags_r;
    logic             branch_taken_r;

    logic             taken_s;
    logic             branch_next_s;
    logic             capture_s;

    // Condition-code decode against a {V,C,N,Z} flag vector.
    function automatic logic cond_met(input logic [3:0] cc, input logic [3:0] fl);
        logic v;
        logic c;
        logic n;
        logic z;
        logic met;
        v = fl[3];
        c = fl[2];
        n = fl[1];
        z = fl[0];
        case (cc)
            4'd0:    met = z;
            4'd1:    met = ~z;
            4'd2:    met = c;
            4'd3:    met = ~c;
            4'd4:    met = n;
            4'd5:    met = ~n;
            4'd6:    met = v;
            4'd7:    met = ~v;
            4'd8:    met = c & ~z;
            4'd9:    met = ~c | z;
            4'd10:   met = (n == v);
            4'd11:   met = (n != v);
            4'd12:   met = ~z & (n == v);
            4'd13:   met = z | (n != v);
            4'd14:   met = 1'b1;
            4'd15:   met = 1'b1;
            default: met = 1'b0;
        endcase
        return met;
    endfunction

    // Branch decision for the instruction presented this cycle; B.cond sees the pre-update flags.
    always_comb begin
        taken_s = 1'b0;
        case (bus.br_type)
            2'b01:   taken_s = cond_met(bus.cond, flags_r);
            2'b10:   taken_s = (bus.F == {WIDTH{1'b0}});
            2'b11:   taken_s = (bus.F != {WIDTH{1'b0}});
            default: taken_s = 1'b0;
        endcase
        branch_next_s = bus.valid_in & taken_s;
        capture_s     = ~bus.stall & ~bus.flush;
    end

    // Stage registers: flush squashes, stall holds, otherwise capture.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            result_r        <= {WIDTH{1'b0}};
            rd_out_r        <= 5'd0;
            reg_write_out_r <= 1'b0;
            valid_out_r     <= 1'b0;
            flags_r         <= 4'b0000;
            branch_taken_r  <= 1'b0;
        end else if (bus.flush) begin
            valid_out_r     <= 1'b0;
            reg_write_out_r <= 1'b0;
            branch_taken_r  <= 1'b0;
        end else if (capture_s) begin
            result_r        <= bus.F;
            rd_out_r        <= bus.rd;
            valid_out_r     <= bus.valid_in;
            reg_write_out_r <= bus.valid_in & bus.reg_write;
            branch_taken_r  <= branch_next_s;
            if (bus.valid_in && bus.set_flags) begin
                flags_r <= bus.status;
            end else begin
                flags_r <= flags_r;
            end
        end else begin
            result_r        <= result_r;
            rd_out_r        <= rd_out_r;
            reg_write_out_r <= reg_write_out_r;
            valid_out_r     <= valid_out_r;
            flags_r         <= flags_r;
            branch_taken_r  <= branch_taken_r;
        end
    end

    assign bus.result        = result_r;
    assign bus.rd_out        = rd_out_r;
    assign bus.reg_write_out = reg_write_out_r;
    assign bus.valid_out     = valid_out_r;
    assign bus.flags         = flags_r;
    assign bus.branch_taken  = branch_taken_r;
endmodule
